// File: rtl/bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : bus_bridge
// Description : Host register-bus bridge between the asynchronous m68k-style
//               bus pins and the pixel-clock domain. Every bus input is
//               synchronised, chip select is glitch-filtered, and each accepted
//               chip-select assertion becomes exactly one register read or
//               write. In 8-bit mode, even/odd byte writes can be paired into
//               one 16-bit write.
// Ports       : clk              - pixel clock, the only clock
//               reset_i          - synchronous active-high reset
//               bus_cs_n_i       - async chip select (active low)
//               bus_rd_nwr_i     - async read(1)/write(0)
//               bus_bytesel_i    - async byte select (0 = bits 15:8, 1 = 7:0)
//               bus_reg_num_i    - async register number
//               bus_data_i       - async write data
//               bus_data_o       - read data to the pads
//               bus_out_ena_o    - pad output enable (combinational)
//               write_strobe_o   - one-cycle register write pulse
//               write_reg_num_o  - write register number
//               write_data_o     - write data
//               write_bytemask_o - [1] bits 15:8 valid, [0] bits 7:0 valid
//               read_strobe_o    - one-cycle register read request
//               read_reg_num_o   - read register number
//               read_data_i      - read data, valid the cycle after the request
// Revision    : 1.0 - initial release
// ============================================================================
module bus_bridge #(
    parameter int BUS_WIDTH   = 8,
    parameter int REG_BITS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CS_FILTER   = 1,
    parameter int WRITE_PAIR  = 1
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 bus_cs_n_i,
    input  logic                 bus_rd_nwr_i,
    input  logic                 bus_bytesel_i,
    input  logic [REG_BITS-1:0]  bus_reg_num_i,
    input  logic [BUS_WIDTH-1:0] bus_data_i,
    output logic [BUS_WIDTH-1:0] bus_data_o,
    output logic                 bus_out_ena_o,
    output logic                 write_strobe_o,
    output logic [REG_BITS-1:0]  write_reg_num_o,
    output logic [15:0]          write_data_o,
    output logic [1:0]           write_bytemask_o,
    output logic                 read_strobe_o,
    output logic [REG_BITS-1:0]  read_reg_num_o,
    input  logic [15:0]          read_data_i
);

    localparam int c_CNT_W = $clog2(CS_FILTER + 1);

    localparam logic [0:0] S_IDLE         = 1'b0;
    localparam logic [0:0] S_WAIT_RELEASE = 1'b1;

    generate
        if (BUS_WIDTH != 8 && BUS_WIDTH != 16) begin : g_bad_width
            $error("bus_bridge: BUS_WIDTH must be 8 or 16");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("bus_bridge: SYNC_STAGES must be at least 2");
        end
        if (CS_FILTER < 1) begin : g_bad_filter
            $error("bus_bridge: CS_FILTER must be at least 1");
        end
    endgenerate

    // Synchroniser chains
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic [SYNC_STAGES-1:0] r_bs_sync;
    logic [REG_BITS-1:0]    r_reg_sync  [SYNC_STAGES];
    logic [BUS_WIDTH-1:0]   r_data_sync [SYNC_STAGES];
    // Fills with ones after reset; the FSM may only trust cs_n_s once the
    // chain holds samples taken after reset (the reset value 1 is not a
    // real release).
    logic [SYNC_STAGES-1:0] r_primed;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_cs_sync <= '1;
            r_rd_sync <= '0;
            r_bs_sync <= '0;
            r_primed  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_reg_sync[i]  <= '0;
                r_data_sync[i] <= '0;
            end
        end else begin
            r_cs_sync <= {r_cs_sync[SYNC_STAGES-2:0], bus_cs_n_i};
            r_rd_sync <= {r_rd_sync[SYNC_STAGES-2:0], bus_rd_nwr_i};
            r_bs_sync <= {r_bs_sync[SYNC_STAGES-2:0], bus_bytesel_i};
            r_primed  <= {r_primed[SYNC_STAGES-2:0], 1'b1};
            r_reg_sync[0]  <= bus_reg_num_i;
            r_data_sync[0] <= bus_data_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_reg_sync[i]  <= r_reg_sync[i-1];
                r_data_sync[i] <= r_data_sync[i-1];
            end
        end
    end

    logic                w_cs_n_s;
    logic                w_rd_s;
    logic                w_bs_s;
    logic                w_primed;
    logic [REG_BITS-1:0] w_reg_s;
    logic [15:0]         w_data16;
    logic [7:0]          w_byte;

    assign w_cs_n_s = r_cs_sync[SYNC_STAGES-1];
    assign w_rd_s   = r_rd_sync[SYNC_STAGES-1];
    assign w_bs_s   = r_bs_sync[SYNC_STAGES-1];
    assign w_primed = r_primed[SYNC_STAGES-1];
    assign w_reg_s  = r_reg_sync[SYNC_STAGES-1];
    assign w_data16 = 16'(r_data_sync[SYNC_STAGES-1]);
    assign w_byte   = w_data16[7:0];

    // Fast, unsynchronised pad enable
    assign bus_out_ena_o = !bus_cs_n_i && bus_rd_nwr_i && !reset_i;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [7:0]         r_even;      // buffered even byte for write pairing
    logic               r_cap_bs;    // bytesel captured with the read request
    logic [15:0]        r_rd_latch;
    logic               r_out_bs;    // bytesel that goes with r_rd_latch

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state          <= S_WAIT_RELEASE;
            r_cnt            <= '0;
            r_even           <= '0;
            r_cap_bs         <= 1'b0;
            r_rd_latch       <= '0;
            r_out_bs         <= 1'b0;
            write_strobe_o   <= 1'b0;
            write_reg_num_o  <= '0;
            write_data_o     <= '0;
            write_bytemask_o <= '0;
            read_strobe_o    <= 1'b0;
            read_reg_num_o   <= '0;
        end else begin
            write_strobe_o <= 1'b0;
            read_strobe_o  <= 1'b0;

            // read_data_i is valid the cycle after the request; the
            // output byte select switches together with the data so the
            // pads keep the previous value until then.
            if (read_strobe_o) begin
                r_rd_latch <= read_data_i;
                r_out_bs   <= r_cap_bs;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_cnt == c_CNT_W'(CS_FILTER)) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_RELEASE;
                        if (w_rd_s) begin
                            read_strobe_o  <= 1'b1;
                            read_reg_num_o <= w_reg_s;
                            r_cap_bs       <= w_bs_s;
                        end else if (BUS_WIDTH == 16) begin
                            write_strobe_o   <= 1'b1;
                            write_reg_num_o  <= w_reg_s;
                            write_data_o     <= w_data16;
                            write_bytemask_o <= 2'b11;
                        end else if (WRITE_PAIR == 0) begin
                            write_strobe_o   <= 1'b1;
                            write_reg_num_o  <= w_reg_s;
                            write_data_o     <= {w_byte, w_byte};
                            write_bytemask_o <= w_bs_s ? 2'b01 : 2'b10;
                        end else if (!w_bs_s) begin
                            r_even <= w_byte;
                        end else begin
                            write_strobe_o   <= 1'b1;
                            write_reg_num_o  <= w_reg_s;
                            write_data_o     <= {r_even, w_byte};
                            write_bytemask_o <= 2'b11;
                        end
                    end else if (!w_cs_n_s) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                S_WAIT_RELEASE: begin
                    if (w_cs_n_s && w_primed) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= S_WAIT_RELEASE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus_data_o = '0;
        if (BUS_WIDTH == 16) begin
            bus_data_o = BUS_WIDTH'(r_rd_latch);
        end else begin
            bus_data_o = BUS_WIDTH'(r_out_bs ? r_rd_latch[7:0] : r_rd_latch[15:8]);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_bridge
// Description : Self-checking bench for bus_bridge. Three instances share the
//               bus pins: A = 8-bit/paired/filter 1, B = 8-bit/unpaired/
//               filter 2, C = 16-bit/filter 1. A transaction-level model
//               predicts strobes, data and pad read data for each instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_bridge;

    localparam int c_SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        rd_nwr;
    logic        bytesel;
    logic [3:0]  reg_num;
    logic [15:0] din;
    logic [15:0] rdata;

    logic [2:0]  wstb, rstb, oe;
    logic [3:0]  wreg  [3];
    logic [3:0]  rreg  [3];
    logic [15:0] wdata [3];
    logic [1:0]  wmask [3];
    logic [7:0]  a_bdo, b_bdo;
    logic [15:0] c_bdo;

    always #5 clk = ~clk;

    bus_bridge #(.BUS_WIDTH(8), .REG_BITS(4), .SYNC_STAGES(c_SYNC), .CS_FILTER(1), .WRITE_PAIR(1)) u_a (
        .clk(clk), .reset_i(rst), .bus_cs_n_i(cs_n), .bus_rd_nwr_i(rd_nwr),
        .bus_bytesel_i(bytesel), .bus_reg_num_i(reg_num), .bus_data_i(din[7:0]),
        .bus_data_o(a_bdo), .bus_out_ena_o(oe[0]), .write_strobe_o(wstb[0]),
        .write_reg_num_o(wreg[0]), .write_data_o(wdata[0]), .write_bytemask_o(wmask[0]),
        .read_strobe_o(rstb[0]), .read_reg_num_o(rreg[0]), .read_data_i(rdata));

    bus_bridge #(.BUS_WIDTH(8), .REG_BITS(4), .SYNC_STAGES(c_SYNC), .CS_FILTER(2), .WRITE_PAIR(0)) u_b (
        .clk(clk), .reset_i(rst), .bus_cs_n_i(cs_n), .bus_rd_nwr_i(rd_nwr),
        .bus_bytesel_i(bytesel), .bus_reg_num_i(reg_num), .bus_data_i(din[7:0]),
        .bus_data_o(b_bdo), .bus_out_ena_o(oe[1]), .write_strobe_o(wstb[1]),
        .write_reg_num_o(wreg[1]), .write_data_o(wdata[1]), .write_bytemask_o(wmask[1]),
        .read_strobe_o(rstb[1]), .read_reg_num_o(rreg[1]), .read_data_i(rdata));

    bus_bridge #(.BUS_WIDTH(16), .REG_BITS(4), .SYNC_STAGES(c_SYNC), .CS_FILTER(1), .WRITE_PAIR(1)) u_c (
        .clk(clk), .reset_i(rst), .bus_cs_n_i(cs_n), .bus_rd_nwr_i(rd_nwr),
        .bus_bytesel_i(bytesel), .bus_reg_num_i(reg_num), .bus_data_i(din),
        .bus_data_o(c_bdo), .bus_out_ena_o(oe[2]), .write_strobe_o(wstb[2]),
        .write_reg_num_o(wreg[2]), .write_data_o(wdata[2]), .write_bytemask_o(wmask[2]),
        .read_strobe_o(rstb[2]), .read_reg_num_o(rreg[2]), .read_data_i(rdata));

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [3:0]  rg;
        logic [15:0] data;
        logic [1:0]  mask;
        logic [15:0] bdo;
    } exp_t;

    typedef struct {
        bit          rd;
        bit          bs;
        logic [3:0]  rg;
        logic [15:0] data;
        logic [15:0] rdat;
        int          low;
        bit          exp_wr;
        bit          exp_rd;
        logic [15:0] exp_data;
        logic [1:0]  exp_mask;
        logic [15:0] exp_bdo;
    } vec_t;

    // Model state per instance
    logic [7:0]  m_even [3];
    logic [15:0] m_bdo  [3];

    function automatic int cfg_f(int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int cfg_bw(int i);
        return (i == 2) ? 16 : 8;
    endfunction

    function automatic int cfg_wp(int i);
        return (i == 1) ? 0 : 1;
    endfunction

    function automatic logic [15:0] get_bdo(int i);
        case (i)
            0:       return {8'h00, a_bdo};
            1:       return {8'h00, b_bdo};
            default: return c_bdo;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_even[i] = '0;
            m_bdo[i]  = '0;
        end
    endfunction

    // One bus access as seen by instance i: an access is accepted when cs_n
    // stays low for at least the filter length.
    function automatic exp_t model(int i, bit rd, bit bs, logic [3:0] rg,
                                   logic [15:0] d, logic [15:0] rdat, int low);
        exp_t e;
        e.wr = 1'b0; e.rd = 1'b0; e.rg = rg; e.data = '0; e.mask = '0;
        if (low >= cfg_f(i)) begin
            if (rd) begin
                e.rd = 1'b1;
                if (cfg_bw(i) == 16) m_bdo[i] = rdat;
                else                 m_bdo[i] = bs ? {8'h00, rdat[7:0]} : {8'h00, rdat[15:8]};
            end else if (cfg_bw(i) == 16) begin
                e.wr = 1'b1; e.data = d; e.mask = 2'b11;
            end else if (cfg_wp(i) == 0) begin
                e.wr = 1'b1; e.data = {d[7:0], d[7:0]}; e.mask = bs ? 2'b01 : 2'b10;
            end else if (!bs) begin
                m_even[i] = d[7:0];
            end else begin
                e.wr = 1'b1; e.data = {m_even[i], d[7:0]}; e.mask = 2'b11;
            end
        end
        e.bdo = m_bdo[i];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_cycle(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s wstb[%0d]", tag, i), 32'(wstb[i]), 32'd0);
            chk($sformatf("%s rstb[%0d]", tag, i), 32'(rstb[i]), 32'd0);
        end
    endtask

    // Drive one access (cs_n low for 'low' edges) and check every cycle.
    task automatic run_access(input bit rd, input bit bs, input logic [3:0] rg,
                              input logic [15:0] d, input logic [15:0] rdat,
                              input int low, input exp_t e [3]);
        @(negedge clk);
        cs_n = 1'b0; rd_nwr = rd; bytesel = bs; reg_num = rg; din = d; rdata = rdat;
        for (int k = 0; k < low + 6; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                bit at_fire;
                at_fire = (k == c_SYNC + cfg_f(i));
                chk($sformatf("wstb[%0d] E%0d", i, k), 32'(wstb[i]), 32'(e[i].wr && at_fire));
                chk($sformatf("rstb[%0d] E%0d", i, k), 32'(rstb[i]), 32'(e[i].rd && at_fire));
                chk($sformatf("oe[%0d] E%0d", i, k), 32'(oe[i]), 32'(!cs_n && rd_nwr && !rst));
                if (e[i].wr && at_fire) begin
                    chk($sformatf("wreg[%0d]", i), 32'(wreg[i]), 32'(e[i].rg));
                    chk($sformatf("wdata[%0d]", i), 32'(wdata[i]), 32'(e[i].data));
                    chk($sformatf("wmask[%0d]", i), 32'(wmask[i]), 32'(e[i].mask));
                end
                if (e[i].rd && at_fire)
                    chk($sformatf("rreg[%0d]", i), 32'(rreg[i]), 32'(e[i].rg));
            end
            @(negedge clk);
            if (k + 1 >= low) cs_n = 1'b1;
        end
        for (int i = 0; i < 3; i++)
            chk($sformatf("bus_data[%0d]", i), 32'(get_bdo(i)), 32'(e[i].bdo));
    endtask

    vec_t tbl [9];
    exp_t ex  [3];

    initial begin
        // Expectations are for instance A (8-bit, paired, filter 1).
        tbl[0] = '{1'b0, 1'b1, 4'd2, 16'h775A, 16'h0000, 3, 1'b1, 1'b0, 16'h005A, 2'b11, 16'h0000};
        tbl[1] = '{1'b0, 1'b0, 4'd3, 16'h0012, 16'h0000, 2, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000};
        tbl[2] = '{1'b0, 1'b1, 4'd3, 16'h0034, 16'h0000, 2, 1'b1, 1'b0, 16'h1234, 2'b11, 16'h0000};
        tbl[3] = '{1'b1, 1'b0, 4'd5, 16'h0000, 16'hBEEF, 3, 1'b0, 1'b1, 16'h0000, 2'b00, 16'h00BE};
        tbl[4] = '{1'b1, 1'b1, 4'd5, 16'h0000, 16'hBEEF, 1, 1'b0, 1'b1, 16'h0000, 2'b00, 16'h00EF};
        tbl[5] = '{1'b0, 1'b0, 4'd1, 16'h00AB, 16'h0000, 2, 1'b0, 1'b0, 16'h0000, 2'b00, 16'h00EF};
        tbl[6] = '{1'b0, 1'b1, 4'd7, 16'h00CD, 16'h0000, 4, 1'b1, 1'b0, 16'hABCD, 2'b11, 16'h00EF};
        tbl[7] = '{1'b0, 1'b1, 4'd0, 16'h0001, 16'h0000, 6, 1'b1, 1'b0, 16'hAB01, 2'b11, 16'h00EF};
        tbl[8] = '{1'b1, 1'b0, 4'd9, 16'h0000, 16'h1357, 2, 1'b0, 1'b1, 16'h0000, 2'b00, 16'h0013};

        model_reset();
        rst = 1'b1; cs_n = 1'b0; rd_nwr = 1'b0; bytesel = 1'b1;
        reg_num = 4'd2; din = 16'h0000; rdata = 16'h0000;

        // Reset state with cs_n already low
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst wstb[%0d]", i), 32'(wstb[i]), 32'd0);
            chk($sformatf("rst rstb[%0d]", i), 32'(rstb[i]), 32'd0);
            chk($sformatf("rst wdata[%0d]", i), 32'(wdata[i]), 32'd0);
            chk($sformatf("rst wmask[%0d]", i), 32'(wmask[i]), 32'd0);
            chk($sformatf("rst wreg[%0d]", i), 32'(wreg[i]), 32'd0);
            chk($sformatf("rst rreg[%0d]", i), 32'(rreg[i]), 32'd0);
            chk($sformatf("rst bdo[%0d]", i), 32'(get_bdo(i)), 32'd0);
            chk($sformatf("rst oe[%0d]", i), 32'(oe[i]), 32'd0);
        end

        // cs_n low through reset release: nothing may fire
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk_idle_cycle("cs_low_after_reset");
        end
        @(negedge clk); cs_n = 1'b1;
        repeat (6) @(negedge clk);

        // Directed table
        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < 3; i++)
                ex[i] = model(i, tbl[v].rd, tbl[v].bs, tbl[v].rg, tbl[v].data, tbl[v].rdat, tbl[v].low);
            ex[0].wr   = tbl[v].exp_wr;
            ex[0].rd   = tbl[v].exp_rd;
            ex[0].data = tbl[v].exp_data;
            ex[0].mask = tbl[v].exp_mask;
            ex[0].bdo  = tbl[v].exp_bdo;
            run_access(tbl[v].rd, tbl[v].bs, tbl[v].rg, tbl[v].data, tbl[v].rdat, tbl[v].low, ex);
        end

        // Reset in the cycle A's write strobe would fire (E3)
        @(negedge clk);
        cs_n = 1'b0; rd_nwr = 1'b0; bytesel = 1'b1; reg_num = 4'd6; din = 16'h4321;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk_idle_cycle("pre_reset");
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst wstb[%0d]", i), 32'(wstb[i]), 32'd0);
            chk($sformatf("midrst wdata[%0d]", i), 32'(wdata[i]), 32'd0);
            chk($sformatf("midrst wmask[%0d]", i), 32'(wmask[i]), 32'd0);
            chk($sformatf("midrst wreg[%0d]", i), 32'(wreg[i]), 32'd0);
            chk($sformatf("midrst bdo[%0d]", i), 32'(get_bdo(i)), 32'd0);
        end
        @(negedge clk); rst = 1'b0;
        model_reset();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            chk_idle_cycle("post_midrst");
        end
        @(negedge clk); cs_n = 1'b1;
        repeat (6) @(negedge clk);

        // Randomised accesses against the model
        for (int n = 0; n < 60; n++) begin
            bit          r_rd, r_bs;
            logic [3:0]  r_rg;
            logic [15:0] r_d, r_rdat;
            int          r_low;
            r_rd   = ($urandom_range(0, 2) == 0);
            r_bs   = 1'($urandom_range(0, 1));
            r_rg   = 4'($urandom);
            r_d    = 16'($urandom);
            r_rdat = 16'($urandom);
            r_low  = $urandom_range(1, 5);
            for (int i = 0; i < 3; i++)
                ex[i] = model(i, r_rd, r_bs, r_rg, r_d, r_rdat, r_low);
            run_access(r_rd, r_bs, r_rg, r_d, r_rdat, r_low, ex);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
